// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, instruction-type codes
// and the per-entry payload record.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_LOG = 4;
  localparam int ROB_SIZE     = 1 << ROB_SIZE_LOG;
  localparam int TAG_W        = ROB_SIZE_LOG;
  localparam int WORD_W       = 32;
  localparam int REG_W        = 5;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [ROB_SIZE_LOG:0] count_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_W-1:0]      reg_t;

  typedef enum logic [1:0] {
    INSN_REG    = 2'd0,
    INSN_BRANCH = 2'd1,
    INSN_STORE  = 2'd2,
    INSN_JALR   = 2'd3
  } insn_type_e;

  // Payload of one entry; valid/ready live in separate flag vectors.
  typedef struct packed {
    insn_type_e typ;
    reg_t       rd;
    word_t      val;
    logic       pred_taken;
    logic       taken;
    word_t      target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus between the core (master) and the reorder buffer (slave): issue,
// operand query, writeback broadcast, retirement and flush signals.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic       issue_sig;
  reg_t       issue_rd;
  logic [1:0] issue_type;
  logic       issue_pred_taken;
  tag_t       issue_rob_tag;
  logic       full;

  tag_t       query_tag1;
  tag_t       query_tag2;
  logic       query_ready1;
  logic       query_ready2;
  word_t      query_val1;
  word_t      query_val2;

  logic       wb_sig;
  tag_t       wb_tag;
  word_t      wb_val;
  logic       wb_taken;
  word_t      wb_target;

  logic       commit_sig;
  reg_t       commit_reg;
  word_t      commit_val;
  tag_t       commit_rob_tag;
  logic       store_commit_sig;
  tag_t       store_commit_tag;
  logic       clear;
  word_t      clear_pc;

  modport master (
    output issue_sig, issue_rd, issue_type, issue_pred_taken,
    output query_tag1, query_tag2,
    output wb_sig, wb_tag, wb_val, wb_taken, wb_target,
    input  issue_rob_tag, full, query_ready1, query_ready2, query_val1, query_val2,
    input  commit_sig, commit_reg, commit_val, commit_rob_tag,
    input  store_commit_sig, store_commit_tag, clear, clear_pc
  );

  modport slave (
    input  issue_sig, issue_rd, issue_type, issue_pred_taken,
    input  query_tag1, query_tag2,
    input  wb_sig, wb_tag, wb_val, wb_taken, wb_target,
    output issue_rob_tag, full, query_ready1, query_ready2, query_val1, query_val2,
    output commit_sig, commit_reg, commit_val, commit_rob_tag,
    output store_commit_sig, store_commit_tag, clear, clear_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at the tail, collects results
// by tag, retires the oldest completed entry each cycle and raises a flush
// when a mispredicted branch or any jalr retires.
// Optional macro ROB_WB_BYPASS_EN: operand queries also see the writeback
// broadcast of the current cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  reorder_buffer_if.slave rob
);

  logic [ROB_SIZE-1:0] valid_q;
  logic [ROB_SIZE-1:0] ready_q;
  rob_entry_t          entry_q [ROB_SIZE];
  tag_t                head_q, head_d;
  tag_t                tail_q, tail_d;
  count_t              count_q, count_d;

  rob_entry_t head_entry;
  logic       is_full;
  logic       head_done;
  logic       mispredict;
  logic       flush;
  logic       issue_ok;
  logic       wb_ok;

  assign head_entry = entry_q[head_q];
  assign is_full    = (count_q == count_t'(ROB_SIZE));
  assign head_done  = rdy && valid_q[head_q] && ready_q[head_q];
  assign mispredict = (head_entry.typ == INSN_JALR) ||
                      ((head_entry.typ == INSN_BRANCH) &&
                       (head_entry.taken != head_entry.pred_taken));
  assign flush      = head_done && mispredict;
  assign issue_ok   = rdy && rob.issue_sig && !is_full && !flush;
  assign wb_ok      = rdy && rob.wb_sig && valid_q[rob.wb_tag] && !flush;

  assign rob.full          = is_full;
  assign rob.issue_rob_tag = tail_q;

  // Retirement outputs, decoded from the registered head entry.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    rob.commit_sig       = 1'b0;
    rob.commit_reg       = '0;
    rob.commit_val       = '0;
    rob.commit_rob_tag   = '0;
    rob.store_commit_sig = 1'b0;
    rob.store_commit_tag = '0;
    rob.clear            = flush;
    rob.clear_pc         = flush ? head_entry.target : '0;
    if (head_done) begin
      if ((head_entry.typ == INSN_REG || head_entry.typ == INSN_JALR) &&
          head_entry.rd != '0) begin
        rob.commit_sig     = 1'b1;
        rob.commit_reg     = head_entry.rd;
        rob.commit_val     = head_entry.val;
        rob.commit_rob_tag = head_q;
      end
      if (head_entry.typ == INSN_STORE) begin
        rob.store_commit_sig = 1'b1;
        rob.store_commit_tag = head_q;
      end
    end
  end

  // Operand lookup by tag, optionally forwarding the live writeback.
  always_comb begin
    rob.query_ready1 = valid_q[rob.query_tag1] && ready_q[rob.query_tag1];
    rob.query_ready2 = valid_q[rob.query_tag2] && ready_q[rob.query_tag2];
    rob.query_val1   = rob.query_ready1 ? entry_q[rob.query_tag1].val : '0;
    rob.query_val2   = rob.query_ready2 ? entry_q[rob.query_tag2].val : '0;
`ifdef ROB_WB_BYPASS_EN
    if (rob.wb_sig && rob.wb_tag == rob.query_tag1 && valid_q[rob.query_tag1]) begin
      rob.query_ready1 = 1'b1;
      rob.query_val1   = rob.wb_val;
    end
    if (rob.wb_sig && rob.wb_tag == rob.query_tag2 && valid_q[rob.query_tag2]) begin
      rob.query_ready2 = 1'b1;
      rob.query_val2   = rob.wb_val;
    end
`else
    // Registered entries only: a result is visible the cycle after writeback.
`endif
  end

  // Next pointer/count: flush rewinds everything, otherwise issue and retire
  // each move their own pointer and cancel out in the count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (head_done) head_d = head_q + tag_t'(1);
      if (issue_ok)  tail_d = tail_q + tag_t'(1);
      count_d = count_q + count_t'(issue_ok) - count_t'(head_done);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Valid/ready flags: reset and flush invalidate every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (wb_ok)     ready_q[rob.wb_tag] <= 1'b1;
      if (head_done) valid_q[head_q]     <= 1'b0;
      if (issue_ok) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
      end
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; nothing reads it unless the
    // matching valid/ready flags, which are reset, say it is live.
    if (wb_ok) begin
      entry_q[rob.wb_tag].val    <= rob.wb_val;
      entry_q[rob.wb_tag].taken  <= rob.wb_taken;
      entry_q[rob.wb_tag].target <= rob.wb_target;
    end
    if (issue_ok) begin
      entry_q[tail_q].typ        <= insn_type_e'(rob.issue_type);
      entry_q[tail_q].rd         <= rob.issue_rd;
      entry_q[tail_q].pred_taken <= rob.issue_pred_taken;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core. It allocates a rename tag per issued instruction and collects execution results by tag. It retires the oldest completed entry each cycle into the register file (reg, value, tag) and the load/store buffer. On a retired branch misprediction it raises the global flush.

## Interface
- ROB_SIZE_LOG, 4: log2 of entry count; tags are ROB_SIZE_LOG bits (16 entries).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state and forces commit_sig/store_commit_sig/clear low.
- issue_sig  in  1  dispatcher allocates an entry this cycle.
- issue_rd  in  5  destination register (0 = none).
- issue_type  in  2  0 reg-write, 1 branch, 2 store, 3 jalr.
- issue_pred_taken  in  1  predictor decision (branch only).
- issue_rob_tag  out  4  tag the next issue receives (tail pointer).
- full  out  1  no free entry; dispatcher must not issue.
- query_tag1, query_tag2  in  4  operand tags to look up.
- query_ready1, query_ready2  out  1  entry holds its result.
- query_val1, query_val2  out  32  result value of that entry.
- wb_sig  in  1  execution result broadcast.
- wb_tag  in  4  entry completed.
- wb_val  in  32  result value.
- wb_taken  in  1  actual branch direction.
- wb_target  in  32  correct next PC (branch/jalr).
- commit_sig  out  1  head retires a register write.
- commit_reg  out  5  destination of the retiring entry.
- commit_val  out  32  value of the retiring entry.
- commit_rob_tag  out  4  tag of the retiring entry.
- store_commit_sig  out  1  head store may write memory.
- store_commit_tag  out  4  tag of that store.
- clear  out  1  flush all speculative state.
- clear_pc  out  32  fetch restart address.

## Operation
- Per entry: valid, ready, type, rd, val, pred_taken, taken, target. Head, tail pointers plus a 5-bit count.
- Issue (issue_sig && !full && !clear): entry[tail] gets valid=1, ready=0, and the fields. Tail is incremented mod 16 and count+1.
- Writeback: entry[wb_tag].ready=1, and val/taken/target are stored. A writeback to an invalid entry is ignored.
- Retire: the head is retire-eligible when valid && ready. One entry per cycle.
  - reg-write/jalr with rd≠0: commit_sig=1 with rd, val, and head tag.
  - store: store_commit_sig=1.
  - branch: no register write.
  - A retiring head does valid=0, head+1, count-1.
- Mispredict: head branch with taken≠pred_taken, or any jalr. clear=1 and clear_pc=target in the same cycle as its retirement. A jalr asserts commit_sig alongside clear.
- Flush: on the edge after clear, all valid bits clear, head=tail=0, count=0. An issue or writeback in the clear cycle is dropped.
- Simultaneous issue and retire: count is unchanged and both pointers advance.
- Query: ready/val are combinational from entry[query_tag].

## Timing
- Reset: every output is 0; all entries are invalid and head=tail=count=0.
- full = (count==16), from registered state. A retire in the same cycle does not free a slot for an issue that cycle.
- Retire outputs are combinational from registered head state. A writeback at edge N can retire in cycle N+1 at the earliest.
- Issue at edge N: issue_rob_tag updates after edge N.
- Pointer wrap 15→0 is seamless. A full ring has head==tail, and count disambiguates.
- Reset mid-operation overrides issue, writeback, and clear.

## Configuration
- ROB_WB_BYPASS_EN defined: query ports also match the current wb_sig/wb_tag and return wb_val with ready=1 in the same cycle.
- Undefined: queries see only registered entries, so the result is visible one cycle after writeback.

## Structure
- Shared package: instruction-type codes, ROB_SIZE_LOG, tag width, 32-bit word width.
- No sub-module is natural. The entry array and the pointer/count logic stay in one module.

## Test plan
- Issue rd=5 (tag 0), writeback tag 0 with val 0x1234 → next cycle commit_sig=1, commit_reg=5, commit_val=0x1234, commit_rob_tag=0.
- Issue 16 entries → full=1. A further issue_sig is ignored and the tail stays 0. Retire one → full=0 the cycle after.
- Writeback tags 2, 1, 0 in that order → retirements occur in order 0, 1, 2 on consecutive cycles.
- Branch pred_taken=0, wb_taken=1, target 0x80 with 3 younger entries → clear=1, clear_pc=0x80. The next cycle count=0 and issue_rob_tag=0.
- Store at head ready → store_commit_sig=1 with its tag, and commit_sig stays 0.
- With ROB_WB_BYPASS_EN defined, query tag 3 in the same cycle as wb of tag 3 with val 7 → query_ready=1, query_val=7. Without the macro → ready=0 that cycle, and ready=1 the next cycle.
